// File: rtl/gpu_pkg.sv
// gpu_pkg: constants and types shared by the rasterizer front end,
// the coverage/colour rasterizer and the framebuffer writer.
//   COORD_W  - width of every screen-space x/y coordinate
//   SCREEN_W - screen width in pixels (legal x is 0..SCREEN_W-1)
//   SCREEN_H - screen height in pixels (legal y is 0..SCREEN_H-1)
//   walker_state_e - state encoding of triangle_bbox_walker
package gpu_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2
  } walker_state_e;

endpackage : gpu_pkg

// File: rtl/bbox_clamp.sv
// bbox_clamp: combinational bounding box of three vertices, clamped to the
// screen.
// Inputs : v1x..v3y - three unsigned vertex coordinates (COORD_W bits each)
// Outputs: min_x/max_x/min_y/max_y - box corners, max clamped to the screen
//          empty - box lies completely right of or below the screen
// When empty is set the corner outputs carry no meaning.
module bbox_clamp #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  input  logic [COORD_W-1:0] v3x,
  input  logic [COORD_W-1:0] v3y,
  output logic [COORD_W-1:0] min_x,
  output logic [COORD_W-1:0] max_x,
  output logic [COORD_W-1:0] min_y,
  output logic [COORD_W-1:0] max_y,
  output logic               empty
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  function automatic logic [COORD_W-1:0] min3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic [COORD_W-1:0] raw_max_x;
  logic [COORD_W-1:0] raw_max_y;

  always_comb begin
    min_x     = min3(v1x, v2x, v3x);
    min_y     = min3(v1y, v2y, v3y);
    raw_max_x = max3(v1x, v2x, v3x);
    raw_max_y = max3(v1y, v2y, v3y);
    max_x     = (raw_max_x > X_LIM) ? X_LIM : raw_max_x;
    max_y     = (raw_max_y > Y_LIM) ? Y_LIM : raw_max_y;
    // Only the minimum can be off-screen; once it is on-screen the clamped
    // maximum is guaranteed to be >= it.
    empty     = (min_x > X_LIM) || (min_y > Y_LIM);
  end

endmodule : bbox_clamp

// File: rtl/triangle_bbox_walker.sv
// triangle_bbox_walker: accepts one triangle per tri handshake, computes its
// screen-clamped bounding box and walks every pixel of the box in raster
// order, one pixel per pix handshake.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   tri_valid/tri_ready   - triangle handshake; v1x..v3y sampled on it
//   lat_v1x..lat_v3y      - latched vertices, stable for the whole walk
//   pix_valid/pix_ready   - pixel handshake
//   pix_x, pix_y          - current pixel; pix_last marks the final one
//   busy                  - any state other than IDLE
module triangle_bbox_walker
  import gpu_pkg::*;
#(
  parameter int COORD_W  = gpu_pkg::COORD_W,
  parameter int SCREEN_W = gpu_pkg::SCREEN_W,
  parameter int SCREEN_H = gpu_pkg::SCREEN_H
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  input  logic [COORD_W-1:0] v3x,
  input  logic [COORD_W-1:0] v3y,
  output logic [COORD_W-1:0] lat_v1x,
  output logic [COORD_W-1:0] lat_v1y,
  output logic [COORD_W-1:0] lat_v2x,
  output logic [COORD_W-1:0] lat_v2y,
  output logic [COORD_W-1:0] lat_v3x,
  output logic [COORD_W-1:0] lat_v3y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               busy
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  walker_state_e state_q, state_d;

  logic [COORD_W-1:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic [COORD_W-1:0] v1x_d, v1y_d, v2x_d, v2y_d, v3x_d, v3y_d;
  logic [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
  logic [COORD_W-1:0] min_x_d, max_x_d, min_y_d, max_y_d;
  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic               last_q, last_d;

  logic [COORD_W-1:0] bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic               bb_empty;

  // The box is computed from the latched vertices, so it is valid in SETUP.
  bbox_clamp #(
    .COORD_W  (COORD_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox_clamp (
    .v1x   (v1x_q),
    .v1y   (v1y_q),
    .v2x   (v2x_q),
    .v2y   (v2y_q),
    .v3x   (v3x_q),
    .v3y   (v3y_q),
    .min_x (bb_min_x),
    .max_x (bb_max_x),
    .min_y (bb_min_y),
    .max_y (bb_max_y),
    .empty (bb_empty)
  );

  always_comb begin
    state_d = state_q;
    v1x_d   = v1x_q;
    v1y_d   = v1y_q;
    v2x_d   = v2x_q;
    v2y_d   = v2y_q;
    v3x_d   = v3x_q;
    v3y_d   = v3y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    x_d     = x_q;
    y_d     = y_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (tri_valid) begin
          v1x_d   = v1x;
          v1y_d   = v1y;
          v2x_d   = v2x;
          v2y_d   = v2y;
          v3x_d   = v3x;
          v3y_d   = v3y;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (bb_empty) begin
          state_d = IDLE;
        end else begin
          min_x_d = bb_min_x;
          max_x_d = bb_max_x;
          min_y_d = bb_min_y;
          max_y_d = bb_max_y;
          x_d     = bb_min_x;
          y_d     = bb_min_y;
          // A single-pixel box is its own last beat.
          last_d  = (bb_min_x == bb_max_x) && (bb_min_y == bb_max_y);
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (pix_ready) begin
          if ((x_q == max_x_q) && (y_q == max_y_q)) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else if (x_q == max_x_q) begin
            x_d    = min_x_q;
            y_d    = y_q + ONE;
            // pix_last is registered, so it is predicted for the next pixel.
            last_d = (min_x_q == max_x_q) && ((y_q + ONE) == max_y_q);
          end else begin
            x_d    = x_q + ONE;
            last_d = ((x_q + ONE) == max_x_q) && (y_q == max_y_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      v1x_q   <= '0;
      v1y_q   <= '0;
      v2x_q   <= '0;
      v2y_q   <= '0;
      v3x_q   <= '0;
      v3y_q   <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v1x_q   <= v1x_d;
      v1y_q   <= v1y_d;
      v2x_q   <= v2x_d;
      v2y_q   <= v2y_d;
      v3x_q   <= v3x_d;
      v3y_q   <= v3y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
    end
  end

  assign tri_ready = (state_q == IDLE);
  assign pix_valid = (state_q == SCAN);
  assign busy      = (state_q != IDLE);
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_last  = last_q;
  assign lat_v1x   = v1x_q;
  assign lat_v1y   = v1y_q;
  assign lat_v2x   = v2x_q;
  assign lat_v2y   = v2y_q;
  assign lat_v3x   = v3x_q;
  assign lat_v3y   = v3y_q;

endmodule : triangle_bbox_walker

// File: tb/tb_triangle_bbox_walker.sv
// Directed testbench for triangle_bbox_walker. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled at the same point.
module tb_triangle_bbox_walker;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tri_valid;
  logic          tri_ready;
  logic [CW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic [CW-1:0] lat_v1x, lat_v1y, lat_v2x, lat_v2y, lat_v3x, lat_v3y;
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int ev[6];

  triangle_bbox_walker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .v1x       (v1x),
    .v1y       (v1y),
    .v2x       (v2x),
    .v2y       (v2y),
    .v3x       (v3x),
    .v3y       (v3y),
    .lat_v1x   (lat_v1x),
    .lat_v1y   (lat_v1y),
    .lat_v2x   (lat_v2x),
    .lat_v2y   (lat_v2y),
    .lat_v3x   (lat_v3x),
    .lat_v3y   (lat_v3y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lat(input string tag);
    check({tag, "_lat_v1x"}, 32'(lat_v1x), 32'(ev[0]));
    check({tag, "_lat_v1y"}, 32'(lat_v1y), 32'(ev[1]));
    check({tag, "_lat_v2x"}, 32'(lat_v2x), 32'(ev[2]));
    check({tag, "_lat_v2y"}, 32'(lat_v2y), 32'(ev[3]));
    check({tag, "_lat_v3x"}, 32'(lat_v3x), 32'(ev[4]));
    check({tag, "_lat_v3y"}, 32'(lat_v3y), 32'(ev[5]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tri_ready"}, 32'(tri_ready), 32'd1);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_last"},  32'(pix_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_pix_x"},     32'(pix_x),     32'd0);
    check({tag, "_pix_y"},     32'(pix_y),     32'd0);
    ev = '{0, 0, 0, 0, 0, 0};
    check_lat(tag);
  endtask

  // Handshake a triangle, then check the SETUP cycle.
  task automatic send_tri(input string tag, input int ax, ay, bx, by, cx, cy);
    ev = '{ax, ay, bx, by, cx, cy};
    v1x = CW'(ax); v1y = CW'(ay);
    v2x = CW'(bx); v2y = CW'(by);
    v3x = CW'(cx); v3y = CW'(cy);
    tri_valid = 1'b1;
    check({tag, "_idle_tri_ready"}, 32'(tri_ready), 32'd1);
    check({tag, "_idle_busy"},      32'(busy),      32'd0);
    tick();
    tri_valid = 1'b0;
    v1x = '1; v1y = '1; v2x = '1; v2y = '1; v3x = '1; v3y = '1;
    check({tag, "_setup_tri_ready"}, 32'(tri_ready), 32'd0);
    check({tag, "_setup_busy"},      32'(busy),      32'd1);
    check({tag, "_setup_pix_valid"}, 32'(pix_valid), 32'd0);
    check_lat({tag, "_setup"});
    tick();
  endtask

  // Walk box x0..x1, y0..y1. mode 0: ready always; mode 1: ready 1,0,0,...
  // stop_after > 0 returns after that many beats without end checks.
  task automatic walk(input string tag, input int x0, x1, y0, y1,
                      input int mode, input int stop_after);
    int  ex    = x0;
    int  ey    = y0;
    int  beats = 0;
    int  cyc   = 0;
    bit  done  = 0;
    bit  rdy;
    while (!done && cyc < 2000) begin
      rdy       = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      pix_ready = rdy;
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'd1);
      check({tag, "_tri_ready"}, 32'(tri_ready), 32'd0);
      check({tag, "_pix_x"},     32'(pix_x),     32'(ex));
      check({tag, "_pix_y"},     32'(pix_y),     32'(ey));
      check({tag, "_pix_last"},  32'(pix_last),  32'((ex == x1) && (ey == y1)));
      if (cyc % 8 == 0) check_lat(tag);
      tick();
      cyc++;
      if (rdy) begin
        beats++;
        if (ex == x1 && ey == y1) done = 1;
        else if (ex == x1) begin ex = x0; ey++; end
        else ex++;
        if (stop_after > 0 && beats == stop_after) return;
      end
    end
    pix_ready = 1'b0;
    if (!done) check({tag, "_walk_timeout"}, 32'd0, 32'd1);
    $display("%s: walk of %0d beats in %0d cycles", tag, beats, cyc);
    check({tag, "_end_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_end_tri_ready"}, 32'(tri_ready), 32'd1);
    check({tag, "_end_busy"},      32'(busy),      32'd0);
    check({tag, "_end_pix_last"},  32'(pix_last),  32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    tri_valid = 1'b0;
    pix_ready = 1'b0;
    v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
    #2;
    check_reset_outputs("reset");
    #15 reset_n = 1'b1;
    tick();
    $display("reset: outputs at reset values");

    // Basic walk, ready held high.
    send_tri("tri_a", 0, 0, 3, 0, 0, 2);
    walk("tri_a", 0, 3, 0, 2, 0, 0);

    // Same triangle with stalls.
    send_tri("tri_stall", 0, 0, 3, 0, 0, 2);
    walk("tri_stall", 0, 3, 0, 2, 1, 0);

    // Off-screen: empty box, back to IDLE after SETUP.
    send_tri("offscreen", 700, 10, 710, 10, 705, 20);
    check("offscreen_tri_ready", 32'(tri_ready), 32'd1);
    check("offscreen_busy",      32'(busy),      32'd0);
    check("offscreen_pix_valid", 32'(pix_valid), 32'd0);
    tick();
    check("offscreen_idle_pix_valid", 32'(pix_valid), 32'd0);
    $display("offscreen: no beats");

    // Clamping to the bottom-right corner.
    send_tri("clamp", 630, 470, 639, 500, 700, 475);
    walk("clamp", 630, 639, 470, 479, 0, 0);

    // Single-point triangle.
    send_tri("point", 5, 7, 5, 7, 5, 7);
    walk("point", 5, 5, 7, 7, 0, 0);

    // Asynchronous reset in the middle of a walk.
    send_tri("abort", 0, 0, 3, 0, 0, 2);
    walk("abort", 0, 3, 0, 2, 0, 5);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    $display("async_reset: outputs at reset values mid-walk");
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    check("post_reset_pix_valid", 32'(pix_valid), 32'd0);
    send_tri("after_reset", 2, 2, 3, 2, 2, 3);
    walk("after_reset", 2, 3, 2, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_triangle_bbox_walker
